apb_modport: RTL and testbench
==============================

// Module: apb_modport
// PURPOSE
//  Top-level APB subsystem: one APB master bridge driving two APB memory slaves.
//  The user side issues simple transfer requests (write or read).
//  The master runs the APB IDLE/SETUP/ACCESS protocol.
//  Address MSB selects slave 0 or slave 1. Read data returns on o_prdata.
// PARAMETERS
//  AW     9    user address width; bit AW-1 = slave select, bits AW-2:0 = word index
//  DW     8    data width of pwdata/prdata and of each memory word
//  DEPTH  256  words per slave memory (= 2**(AW-1))
// PORTS
//  pclk         in   1   single clock; all state changes on rising edge
//  presetn      in   1   asynchronous, active-low reset
//  i_ptransfer  in   1   transfer request, sampled at rising edge
//  i_pwrite     in   1   1 = write, 0 = read; valid with i_ptransfer
//  i_pwaddr     in   AW  write address
//  i_pwdata     in   DW  write data
//  i_praddr     in   AW  read address
//  o_prdata     out  DW  data of the last completed read
// BEHAVIOUR
//  - Reset (presetn=0, asynchronous assert):
//    - FSM=IDLE; internal psel0/psel1/penable=0; paddr/pwdata/pwrite regs=0
//    - o_prdata=0; both memories cleared to 0
//    - Deassertion is taken at the next rising edge.
//  - FSM states: IDLE, SETUP, ACCESS.
//  - IDLE:
//    - With i_ptransfer=1 at an edge: latch pwrite=i_pwrite and
//      paddr = i_pwrite ? i_pwaddr : i_praddr; latch pwdata=i_pwdata.
//    - Go to SETUP.
//    - Otherwise stay in IDLE, with psel*=0 and penable=0.
//  - SETUP (one cycle):
//    - psel[paddr[AW-1]]=1, other psel=0, penable=0.
//    - Always go to ACCESS.
//  - ACCESS:
//    - psel held, penable=1.
//    - Slaves drive pready=1 in ACCESS (zero wait states); pslverr is tied 0.
//    - At the closing edge, a write stores pwdata into mem[sel][paddr[AW-2:0]].
//    - At the closing edge, a read loads o_prdata with mem[sel][paddr[AW-2:0]].
//    - Next state: SETUP if i_ptransfer=1 (back-to-back; new request latched
//      as in IDLE), otherwise IDLE.
//  - Latency from request edge:
//    - Write: visible in memory 2 edges after the request edge.
//    - Read: o_prdata valid after the 2nd edge following the request edge.
//    - Each transfer takes 2 cycles; back-to-back requests complete one per 2 cycles.
//  - o_prdata holds its value between reads; writes never change it.
//  - Request inputs are ignored in SETUP. The latched request is used, not the live inputs.
//  - Any index 0..DEPTH-1 is valid in either slave; there is no error or wrap case.
//  - Reset in mid-transfer: abort immediately to IDLE. An in-flight write is not
//    committed and o_prdata goes to 0.
//  - Addresses are unsigned. Data is stored and returned unmodified (no arithmetic).
// TESTING
//  1. presetn=0 -> o_prdata=0, FSM IDLE. Release reset, then read addr 9'h005 -> o_prdata=8'h00.
//  2. Write 9'h010=8'hA5 (slave0), then read 9'h010 -> o_prdata=8'hA5, 2 cycles after the read request.
//  3. Write 9'h110=8'h3C (slave1) and 9'h010=8'h77. Read 9'h110 -> 8'h3C;
//     read 9'h010 -> 8'h77 (slaves independent).
//  4. Hold i_ptransfer=1: write 9'h0FF=8'h11, then read 9'h0FF back-to-back ->
//     SETUP follows ACCESS directly; o_prdata=8'h11.
//  5. Boundary: write 9'h000=8'h01 and 9'h1FF=8'hFE, then read both -> 8'h01 and 8'hFE.
//  6. Write 9'h020=8'h55 and assert presetn during ACCESS. Release reset, read 9'h020 -> 8'h00.

Source files
------------

// File: rtl/apb_modport.sv
// APB subsystem: a single-master bridge running IDLE/SETUP/ACCESS, driving two
// zero-wait-state memory slaves chosen by the address MSB.

module apb_mem_slave #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          i_psel,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [IW-1:0] i_paddr,
  input  logic [DW-1:0] i_pwdata,
  output logic [DW-1:0] o_prdata,
  output logic          o_pready,
  output logic          o_pslverr
);

  logic [DW-1:0] r_mem [DEPTH];

  assign o_pready  = i_psel & i_penable;
  assign o_pslverr = 1'b0;
  assign o_prdata  = r_mem[i_paddr];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_psel && i_penable && i_pwrite) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

endmodule

module apb_modport #(
  parameter int AW    = 9,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          i_ptransfer,
  input  logic          i_pwrite,
  input  logic [AW-1:0] i_pwaddr,
  input  logic [DW-1:0] i_pwdata,
  input  logic [AW-1:0] i_praddr,
  output logic [DW-1:0] o_prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_prdata;

  logic          w_psel0;
  logic          w_psel1;
  logic          w_penable;
  logic          w_sel;
  logic [DW-1:0] w_prdata0;
  logic [DW-1:0] w_prdata1;
  logic          w_pready0;
  logic          w_pready1;
  logic          w_pslverr0;
  logic          w_pslverr1;
  logic [DW-1:0] w_prdata;
  logic          w_pready;
  logic          w_pslverr;
  logic          w_done;
  logic          w_latch;

  assign w_sel     = r_paddr[AW-1];
  assign w_prdata  = w_sel ? w_prdata1  : w_prdata0;
  assign w_pready  = w_sel ? w_pready1  : w_pready0;
  assign w_pslverr = w_sel ? w_pslverr1 : w_pslverr0;
  assign w_done    = (r_state == ACCESS) && w_pready;
  // A new request is captured from IDLE or on the closing edge of ACCESS.
  assign w_latch   = i_ptransfer && ((r_state == IDLE) || w_done);
  assign o_prdata  = r_prdata;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_ptransfer ? SETUP : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_pready) w_next = i_ptransfer ? SETUP : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_psel0   = 1'b0;
    w_psel1   = 1'b0;
    w_penable = 1'b0;
    if (r_state == SETUP || r_state == ACCESS) begin
      w_psel0   = ~w_sel;
      w_psel1   = w_sel;
      w_penable = (r_state == ACCESS);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_prdata <= '0;
    end else begin
      if (w_latch) begin
        r_pwrite <= i_pwrite;
        r_paddr  <= i_pwrite ? i_pwaddr : i_praddr;
        r_pwdata <= i_pwdata;
      end
      if (w_done && !r_pwrite && !w_pslverr) r_prdata <= w_prdata;
    end
  end

  apb_mem_slave #(.DW(DW), .DEPTH(DEPTH), .IW(AW-1)) u_slave0 (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_psel    (w_psel0),
    .i_penable (w_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[AW-2:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata0),
    .o_pready  (w_pready0),
    .o_pslverr (w_pslverr0)
  );

  apb_mem_slave #(.DW(DW), .DEPTH(DEPTH), .IW(AW-1)) u_slave1 (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_psel    (w_psel1),
    .i_penable (w_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[AW-2:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata1),
    .o_pready  (w_pready1),
    .o_pslverr (w_pslverr1)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Bench for apb_modport: directed vector table, back-to-back and reset-abort
// sequences, then random transfers against a flat 512-byte memory model.

module tb_apb_modport;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       i_ptransfer;
  logic       i_pwrite;
  logic [8:0] i_pwaddr;
  logic [7:0] i_pwdata;
  logic [8:0] i_praddr;
  logic [7:0] o_prdata;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] refMem [512];
  logic [7:0] expPrdata;

  typedef struct {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  apb_modport dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .i_ptransfer (i_ptransfer),
    .i_pwrite    (i_pwrite),
    .i_pwaddr    (i_pwaddr),
    .i_pwdata    (i_pwdata),
    .i_praddr    (i_praddr),
    .o_prdata    (o_prdata)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] exp);
    nCompared++;
    if (o_prdata !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: o_prdata got %h expected %h", name, o_prdata, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 512; i++) refMem[i] = 8'h00;
    expPrdata = 8'h00;
  endtask

  task automatic scrambleInputs();
    i_pwrite = 1'($urandom);
    i_pwaddr = 9'($urandom);
    i_praddr = 9'($urandom);
    i_pwdata = 8'($urandom);
  endtask

  // One isolated transfer; inputs are scrambled after the request edge so the
  // latched request must be the one used.
  task automatic applyStimulus(input logic wr, input logic [8:0] addr, input logic [7:0] data);
    @(negedge pclk);
    scrambleInputs();
    i_ptransfer = 1'b1;
    i_pwrite    = wr;
    if (wr) begin
      i_pwaddr = addr;
      i_pwdata = data;
    end else begin
      i_praddr = addr;
    end
    @(negedge pclk);
    i_ptransfer = 1'b0;
    scrambleInputs();
    @(negedge pclk);
    checkOutput("hold_before_close", expPrdata);
    @(negedge pclk);
    if (wr) refMem[addr] = data;
    else    expPrdata = refMem[addr];
    checkOutput(wr ? "after_write" : "after_read", expPrdata);
  endtask

  initial begin
    presetn     = 1'b0;
    i_ptransfer = 1'b1;
    scrambleInputs();
    modelReset();

    vecs.push_back('{1'b0, 9'h005, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 9'h010, 8'hA5, 8'h00});
    vecs.push_back('{1'b0, 9'h010, 8'h00, 8'hA5});
    vecs.push_back('{1'b1, 9'h110, 8'h3C, 8'h00});
    vecs.push_back('{1'b1, 9'h010, 8'h77, 8'h00});
    vecs.push_back('{1'b0, 9'h110, 8'h00, 8'h3C});
    vecs.push_back('{1'b0, 9'h010, 8'h00, 8'h77});
    vecs.push_back('{1'b1, 9'h000, 8'h01, 8'h00});
    vecs.push_back('{1'b1, 9'h1FF, 8'hFE, 8'h00});
    vecs.push_back('{1'b0, 9'h000, 8'h00, 8'h01});
    vecs.push_back('{1'b0, 9'h1FF, 8'h00, 8'hFE});

    repeat (3) @(posedge pclk);
    #1 checkOutput("reset_value", 8'h00);
    @(negedge pclk);
    i_ptransfer = 1'b0;
    presetn     = 1'b1;
    @(negedge pclk);
    checkOutput("after_release", 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (!vecs[i].wr) checkOutput($sformatf("table_read_%0d", i), vecs[i].exp);
    end

    // Back-to-back: the read request is presented during SETUP and must be
    // picked up on the closing edge of the write's ACCESS.
    @(negedge pclk);
    i_ptransfer = 1'b1; i_pwrite = 1'b1; i_pwaddr = 9'h0FF; i_pwdata = 8'h11; i_praddr = 9'h000;
    @(negedge pclk);
    i_pwrite = 1'b0; i_praddr = 9'h0FF; i_pwaddr = 9'h1FF; i_pwdata = 8'hEE;
    @(negedge pclk);
    checkOutput("b2b_hold_1", expPrdata);
    @(negedge pclk);
    i_ptransfer = 1'b0;
    refMem[9'h0FF] = 8'h11;
    checkOutput("b2b_after_write", expPrdata);
    @(negedge pclk);
    checkOutput("b2b_hold_2", expPrdata);
    @(negedge pclk);
    expPrdata = refMem[9'h0FF];
    checkOutput("b2b_read", 8'h11);

    // Reset asserted while a write sits in ACCESS.
    @(negedge pclk);
    i_ptransfer = 1'b1; i_pwrite = 1'b1; i_pwaddr = 9'h020; i_pwdata = 8'h55;
    @(negedge pclk);
    i_ptransfer = 1'b0;
    @(negedge pclk);
    presetn = 1'b0;
    #1 checkOutput("abort_clears_prdata", 8'h00);
    modelReset();
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    applyStimulus(1'b0, 9'h020, 8'h00);
    checkOutput("abort_no_commit", 8'h00);

    for (int i = 0; i < 60; i++) begin
      logic       wr;
      logic [8:0] addr;
      wr   = 1'($urandom);
      addr = {1'($urandom), 5'h00, 3'($urandom)};
      if ($urandom_range(0, 7) == 0) addr[7:0] = 8'hFF;
      applyStimulus(wr, addr, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
